// File: rtl/wb_source_sel_pipe.sv
// Write-back source selector with a registered output and a 2-entry skid buffer.
// Optional trace of the accepted select value is enabled by defining WB_SRC_TRACE_EN.
module wb_source_sel_pipe #(
  parameter int          WIDTH     = 32,
  parameter int          NSRC      = 11,
  parameter int          SEL_W     = 4,
  parameter int          CONST_SEL = 7,
  parameter int unsigned CONST_VAL = 227
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NSRC*WIDTH-1:0] src_bus,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
`ifdef WB_SRC_TRACE_EN
  output logic [SEL_W-1:0]      out_sel,
`endif
  input  logic                  out_ready,
  input  logic                  flush,
  output logic                  sel_err,
  input  logic                  err_clr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  localparam logic [WIDTH-1:0] LP_CONST = WIDTH'(CONST_VAL);

  logic [1:0]       r_state;
  logic             r_in_ready;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_sel_err;
`ifdef WB_SRC_TRACE_EN
  logic [SEL_W-1:0] r_main_sel;
  logic [SEL_W-1:0] r_skid_sel;
`endif

  logic [WIDTH-1:0] w_slots [NSRC];
  logic [WIDTH-1:0] w_value;
  logic             w_oor;
  logic             w_accept;
  logic             w_take;
  logic             w_out_valid;
  logic [1:0]       w_state_next;
  logic             w_load_main;
  logic             w_main_from_skid;
  logic             w_load_skid;

  genvar gi;
  generate
    for (gi = 0; gi < NSRC; gi++) begin : g_slot
      if (gi == CONST_SEL) begin : g_const
        assign w_slots[gi] = LP_CONST;
      end else begin : g_bus
        assign w_slots[gi] = src_bus[gi*WIDTH +: WIDTH];
      end
    end
  endgenerate

  // Out-of-range selects fall through with value 0 and raise w_oor.
  always_comb begin
    w_value = '0;
    w_oor   = 1'b1;
    for (int i = 0; i < NSRC; i++) begin
      if (sel == SEL_W'(i)) begin
        w_value = w_slots[i];
        w_oor   = 1'b0;
      end
    end
  end

  assign w_out_valid = (r_state != S_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_take      = w_out_valid & out_ready;

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_next = S_ONE;
          w_load_main  = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_take) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_next = S_TWO;
          w_load_skid  = 1'b1;
        end else if (w_take) begin
          w_state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_take) begin
          w_state_next     = S_ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
    // Flush discards everything, including an accept in the same cycle.
    if (flush) begin
      w_state_next     = S_EMPTY;
      w_load_main      = 1'b0;
      w_main_from_skid = 1'b0;
      w_load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_in_ready <= 1'b0;
      r_main     <= '0;
      r_skid     <= '0;
      r_sel_err  <= 1'b0;
`ifdef WB_SRC_TRACE_EN
      r_main_sel <= '0;
      r_skid_sel <= '0;
`endif
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != S_TWO);
      if (w_load_main) begin
        r_main <= w_value;
`ifdef WB_SRC_TRACE_EN
        r_main_sel <= sel;
`endif
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
`ifdef WB_SRC_TRACE_EN
        r_main_sel <= r_skid_sel;
`endif
      end
      if (w_load_skid) begin
        r_skid <= w_value;
`ifdef WB_SRC_TRACE_EN
        r_skid_sel <= sel;
`endif
      end
      if (w_accept && w_oor) begin
        r_sel_err <= 1'b1;
      end else if (err_clr) begin
        r_sel_err <= 1'b0;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = r_main;
  assign sel_err   = r_sel_err;
`ifdef WB_SRC_TRACE_EN
  assign out_sel   = r_main_sel;
`endif

endmodule

// File: tb/tb_wb_source_sel_pipe.sv
// Directed bench for wb_source_sel_pipe: single-transaction vector table plus
// back-pressure, streaming, sel_err, flush and asynchronous-reset sequences.
module tb_wb_source_sel_pipe;

  localparam int WIDTH = 32;
  localparam int NSRC  = 11;
  localparam int SEL_W = 4;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NSRC*WIDTH-1:0] src_bus;
  logic [SEL_W-1:0]      sel;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  flush;
  logic                  sel_err;
  logic                  err_clr;
`ifdef WB_SRC_TRACE_EN
  logic [SEL_W-1:0]      out_sel;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  wb_source_sel_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_bus   (src_bus),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
`ifdef WB_SRC_TRACE_EN
    .out_sel   (out_sel),
`endif
    .out_ready (out_ready),
    .flush     (flush),
    .sel_err   (sel_err),
    .err_clr   (err_clr)
  );

  typedef struct {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] slot_val;
    logic [WIDTH-1:0] exp_data;
    logic             exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_slot(input int i, input logic [WIDTH-1:0] v);
    src_bus[i*WIDTH +: WIDTH] = v;
  endtask

  initial begin
    reset_n   = 1'b0;
    src_bus   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    err_clr   = 1'b0;

    vecs[0] = '{4'd0,  32'h11111111, 32'h11111111, 1'b0};
    vecs[1] = '{4'd7,  32'hDEADBEEF, 32'h000000E3, 1'b0};
    vecs[2] = '{4'd1,  32'h01234567, 32'h01234567, 1'b0};
    vecs[3] = '{4'd5,  32'hCAFEF00D, 32'hCAFEF00D, 1'b0};
    vecs[4] = '{4'd10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[5] = '{4'd6,  32'h80000001, 32'h80000001, 1'b0};
    vecs[6] = '{4'd12, 32'h0,        32'h00000000, 1'b1};
    vecs[7] = '{4'd3,  32'h0000000B, 32'h0000000B, 1'b1};

    // Reset state
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sel_err", sel_err, 0);
    reset_n = 1'b1;
    step();
    chk("rst_in_ready_rise", in_ready, 1);

    // Single transactions from EMPTY with out_ready=1
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < NSRC; s++) set_slot(s, 32'h5A000000 | s);
      if (vecs[v].sel < NSRC) set_slot(vecs[v].sel, vecs[v].slot_val);
      sel      = vecs[v].sel;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", v), out_valid, 1);
      chk($sformatf("vec%0d_data", v), out_data, vecs[v].exp_data);
      chk($sformatf("vec%0d_err", v), sel_err, vecs[v].exp_err);
`ifdef WB_SRC_TRACE_EN
      chk($sformatf("vec%0d_sel", v), out_sel, vecs[v].sel);
`endif
      step();
      chk($sformatf("vec%0d_drop", v), out_valid, 0);
      $display("[TB] vec %0d sel=%0d data=0x%08h err=%0b", v, vecs[v].sel, out_data, sel_err);
    end

    // sel_err: set beats err_clr, then err_clr alone clears
    sel = 4'd15; in_valid = 1'b1; err_clr = 1'b1;
    step();
    in_valid = 1'b0; err_clr = 1'b0;
    chk("err_set_over_clr", sel_err, 1);
    chk("err_oor_data", out_data, 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("err_clr_alone", sel_err, 0);
    step();
    chk("err_stays_clear", sel_err, 0);

    // Back-pressure: fill to TWO, then drain in order
    set_slot(2, 32'hA); set_slot(3, 32'hB);
    out_ready = 1'b0;
    sel = 4'd2; in_valid = 1'b1;
    step();
    chk("bp_ready_one", in_ready, 1);
    sel = 4'd3;
    step();
    in_valid = 1'b0;
    chk("bp_ready_two", in_ready, 0);
    chk("bp_hold_a", out_data, 32'hA);
    step();
    chk("bp_still_a", out_data, 32'hA);
    chk("bp_still_valid", out_valid, 1);
    out_ready = 1'b1;
    step();
    chk("bp_drain_b", out_data, 32'hB);
    chk("bp_drain_b_valid", out_valid, 1);
    chk("bp_ready_back", in_ready, 1);
    step();
    chk("bp_empty", out_valid, 0);

    // Streaming one per cycle through ONE with accept & take
    set_slot(0, 32'h100); set_slot(1, 32'h101); set_slot(2, 32'h102);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel = SEL_W'(k);
      step();
      chk($sformatf("stream%0d_data", k), out_data, 32'h100 + k);
      chk($sformatf("stream%0d_ready", k), in_ready, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_empty", out_valid, 0);

    // Flush from TWO with out_ready=0
    set_slot(4, 32'h55); set_slot(5, 32'h66);
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 4'd4;
    step();
    sel = 4'd5;
    step();
    in_valid = 1'b0;
    chk("fl_in_two", in_ready, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("fl_no_present1", out_valid, 0);
    step();
    chk("fl_no_present2", out_valid, 0);

    // Asynchronous reset while in TWO with sel_err set
    out_ready = 1'b0;
    in_valid = 1'b1; sel = 4'd12;
    step();
    sel = 4'd4;
    step();
    in_valid = 1'b0;
    chk("ar_pre_two", in_ready, 0);
    chk("ar_pre_err", sel_err, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_err", sel_err, 0);
    chk("ar_ready", in_ready, 0);
    step();
    reset_n = 1'b1;
    step();
    chk("ar_ready_rise", in_ready, 1);
    chk("ar_empty", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_source_sel_pipe.md
Name: wb_source_sel_pipe

Overview:
- Parametrised successor to the combinational write-back data-source selector in the multicycle datapath.
- Selects one of NSRC datapath results, or a built-in constant, and registers the result.
- Delivers the registered result to the register-file write port through a valid/ready handshake.
- A 2-entry skid buffer absorbs write-port back-pressure, so the control unit can issue one selection per cycle without a combinational ready path.

Parameters:
- WIDTH, 32: data width of every source and of the output.
- NSRC, 11: number of source slots packed on src_bus. Legal select values are 0..NSRC-1.
- SEL_W, 4: select width. Must satisfy 2^SEL_W >= NSRC.
- CONST_SEL, 7: slot index replaced by CONST_VAL. The src_bus slice at this index is ignored.
- CONST_VAL, 227: constant driven when CONST_SEL is selected.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous reset, active-low.
- src_bus  in  NSRC*WIDTH  packed sources; slot i = bits [i*WIDTH +: WIDTH].
- sel  in  SEL_W  source select, sampled on accept.
- in_valid  in  1  request to capture a selection.
- in_ready  out  1  block can accept this cycle.
- out_data  out  WIDTH  registered selected value.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer takes out_data this cycle.
- flush  in  1  synchronous discard of all held entries.
- sel_err  out  1  sticky flag: an out-of-range sel was accepted.
- err_clr  in  1  synchronous clear of sel_err.

Behaviour:
- Accept = in_valid & in_ready. Take = out_valid & out_ready.
- Value on accept:
  - sel == CONST_SEL: CONST_VAL, zero-extended or truncated to WIDTH.
  - sel < NSRC otherwise: slot sel of src_bus.
  - sel >= NSRC: value 0, and sel_err sets.
- Storage: main register (drives out_data) plus one skid register.
- States:
  - EMPTY: out_valid=0.
  - ONE: main valid, skid empty.
  - TWO: both valid.
- in_ready = (state != TWO). It is registered: it depends only on state.
- Transitions:
  - EMPTY: accept -> ONE, main <= value.
  - ONE, accept & take -> ONE, main <= value.
  - ONE, accept & !take -> TWO, skid <= value.
  - ONE, take & !accept -> EMPTY.
  - TWO, take -> ONE, main <= skid. No accept is possible in TWO.
  - All other cases: hold.
- Latency: accepted value appears on out_data the next cycle when the block was EMPTY, or ONE with a same-cycle take.
- Ordering: strict FIFO; no reordering or dropping except on flush.
- out_data holds its value while out_valid=1 and out_ready=0. When EMPTY it holds the last value; the value is don't-care but must not be X after reset.
- flush:
  - State -> EMPTY next cycle, regardless of same-cycle accept or take.
  - A same-cycle accept is discarded.
  - sel_err is unaffected.
- sel_err:
  - Sets the cycle after an accept with sel >= NSRC.
  - err_clr clears it.
  - Set has priority over a simultaneous err_clr.
- Reset (asynchronous assert, mid-operation included):
  - state=EMPTY, out_valid=0, in_ready=0 during reset, out_data=0, skid=0, sel_err=0.
  - in_ready rises in the first cycle after deassertion.

Optional Feature:
- Macro: WB_SRC_TRACE_EN.
- Defined:
  - Adds output port out_sel [SEL_W-1:0], the sel value accepted with the current out_data.
  - out_sel travels through main and skid in lockstep with the data.
  - Reset value 0.
- Undefined: port and its storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then src slot 0=0x11111111, sel=0, in_valid=1 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=0x11111111; the cycle after, out_valid=0.
- sel=7 with slot 7 driven 0xDEADBEEF -> out_data=0x000000E3 (227).
- out_ready=0; accept sel=2 (0xA) then sel=3 (0xB) -> in_ready=0 after the second accept. Raise out_ready -> 0xA then 0xB on consecutive cycles, in_ready=1 again.
- sel=12 accepted -> out_data=0, sel_err=1 and stays 1. err_clr together with another sel=15 accept -> sel_err remains 1. err_clr alone -> sel_err=0.
- Block in TWO; flush=1 with out_ready=0 -> next cycle out_valid=0, in_ready=1; neither held value is ever presented.
- Assert reset_n=0 asynchronously while in TWO -> out_valid, out_data, sel_err go 0 immediately, without waiting for a clock edge.
